divider_arbiter: RTL and testbench
==================================

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand, quotient and remainder width.
REQ-002 The block SHALL have parameter R, default 4, giving the number of requesters (R >= 2).
REQ-003 The block SHALL have port i_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_req, input, R bits: per-requester request; bit k is held high until granted.
REQ-006 The block SHALL have port i_dividend, input, R*N bits: requester k operand at bits [k*N+N-1 : k*N].
REQ-007 The block SHALL have port i_divisor, input, R*N bits: same packing as i_dividend.
REQ-008 The block SHALL have port o_grant, output, R bits: one-hot accept pulse; operands of the granted requester are captured that cycle.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port o_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port i_ready, input, 1 bit: result consumer accepts the result.
REQ-012 The block SHALL have port o_id, output, clog2(R) bits: index of the requester owning the result.
REQ-013 The block SHALL have ports o_quotient and o_remainder, outputs, N bits each: the registered result.
REQ-014 The block SHALL have port o_undefined, output, 1 bit: registered divide-by-zero flag.

Function
REQ-015 The block SHALL instantiate exactly one Divider (width N) and share it among all requesters.
REQ-016 The block SHALL implement the FSM IDLE -> START -> BUSY -> DONE -> IDLE.
REQ-017 In IDLE with any i_req bit high, the block SHALL assert o_grant for the winner for one cycle, register the winner's operands and index, and go to START; otherwise it SHALL stay in IDLE with o_grant = 0.
REQ-018 Arbitration SHALL be round-robin: the search starts at the priority pointer; after a grant to k the pointer becomes (k+1) mod R.
REQ-019 In START the block SHALL drive the divider start high for exactly one cycle, with the registered operands, then go to BUSY.
REQ-020 The registered operands SHALL drive the divider unchanged from START until DONE is entered.
REQ-021 In BUSY the block SHALL wait for the divider finished flag; in the cycle it is high, the block SHALL register quotient, remainder and undefined and go to DONE.
REQ-022 Latency SHALL be exactly N+2 cycles from the o_grant cycle to the first o_valid cycle.
REQ-023 In DONE, o_valid SHALL be 1, and o_id and the result outputs SHALL be held stable until i_ready = 1.
REQ-024 When o_valid and i_ready are both high, the block SHALL go to IDLE; no grant SHALL occur in that same cycle.
REQ-025 i_ready SHALL be ignored outside DONE; i_req SHALL be ignored outside IDLE.
REQ-026 A request that drops before it is granted SHALL be forgotten, with no stored state.
REQ-027 A divisor of 0 SHALL NOT be short-circuited; the result SHALL be quotient all-ones, remainder = dividend and o_undefined = 1.
REQ-028 Result outputs SHALL change only on DONE entry or on reset.

Reset
REQ-029 While i_reset is high (at any state, including mid-division), the next edge SHALL set state to IDLE, pointer to 0, o_grant = 0, o_valid = 0, o_busy = 0, o_id = 0, o_quotient = 0, o_remainder = 0 and o_undefined = 0, and SHALL reset the divider.
REQ-030 After reset deasserts, the first grant SHALL follow the REQ-018 rule with pointer 0.

Verification (N=8, R=4)
REQ-031 The bench SHALL cover: req[2] with 100/7 -> o_grant = 0100, and 10 cycles later o_valid = 1, o_id = 2, q = 14, r = 2, o_undefined = 0.
REQ-032 The bench SHALL cover: req = 1111 held with all ops 200/13 -> grants in order 0, 1, 2, 3, 0, each result q = 15, r = 5, with i_ready tied to 1.
REQ-033 The bench SHALL cover: req[1] with 13/0 -> q = 0xFF, r = 13, o_undefined = 1.
REQ-034 The bench SHALL cover: i_ready = 0 for 5 cycles in DONE with 255/1 -> o_valid, o_id, q = 255 and r = 0 stable throughout; no new grant despite req = 1111.
REQ-035 The bench SHALL cover: reset pulse in BUSY -> next cycle o_busy = 0, o_valid = 0, outputs 0; a following req[3] gets a grant, with no stale o_valid.
REQ-036 The bench SHALL cover: req[0] dropped while BUSY serves req[1] -> no grant to 0 afterward.

Source files
------------

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin arbiter sharing one restoring divider among R requesters.
module divider #(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_undefined,
  output logic         o_finished
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0] rem, quo, dsr, rem_in, quo_in, dsr_in, rem_nx;
  logic [N:0] trial;
  logic [CW-1:0] cnt;
  logic ge, fin;
  // The first restoring step runs on the start edge itself, so N steps end after N edges.
  always_comb begin
    rem_in = i_start ? '0 : rem;
    quo_in = i_start ? i_dividend : quo;
    dsr_in = i_start ? i_divisor : dsr;
    trial = {rem_in, quo_in[N-1]};
    ge = trial >= {1'b0, dsr_in};
    rem_nx = ge ? N'(trial - {1'b0, dsr_in}) : trial[N-1:0];
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
      cnt <= '0;
      fin <= 1'b0;
    end else if (i_start || cnt != '0) begin
      rem <= rem_nx;
      quo <= {quo_in[N-2:0], ge};
      dsr <= dsr_in;
      cnt <= i_start ? CW'(N - 1) : cnt - CW'(1);
      fin <= !i_start && cnt == CW'(1);
    end
  end
  assign o_quotient = quo;
  assign o_remainder = rem;
  assign o_undefined = dsr == '0;
  assign o_finished = fin;
endmodule

module divider_arbiter #(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [R-1:0]         i_req,
  input  logic [R*N-1:0]       i_dividend,
  input  logic [R*N-1:0]       i_divisor,
  output logic [R-1:0]         o_grant,
  output logic                 o_busy,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [$clog2(R)-1:0] o_id,
  output logic [N-1:0]         o_quotient,
  output logic [N-1:0]         o_remainder,
  output logic                 o_undefined
);
  localparam int IW = $clog2(R);
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, win, id;
  logic [N-1:0] a_r, b_r, q_r, r_r, div_q, div_r;
  logic hit, grant_en, u_r, div_u, div_fin;
  divider #(.N(N)) u_div (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_start(state == START),
    .i_dividend(a_r),
    .i_divisor(b_r),
    .o_quotient(div_q),
    .o_remainder(div_r),
    .o_undefined(div_u),
    .o_finished(div_fin)
  );
  // Scan downward so the requester closest to the pointer is the last to overwrite win.
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = R - 1; i >= 0; i--) begin
      if (i_req[(int'(ptr) + i) % R]) begin
        win = IW'((int'(ptr) + i) % R);
        hit = 1'b1;
      end
    end
  end
  assign grant_en = state == IDLE && hit && !i_reset;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = hit ? START : IDLE;
      START: state_nx = BUSY;
      BUSY:  state_nx = div_fin ? DONE : BUSY;
      DONE:  state_nx = i_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      a_r <= '0;
      b_r <= '0;
      q_r <= '0;
      r_r <= '0;
      u_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_en) begin
        a_r <= i_dividend[int'(win)*N +: N];
        b_r <= i_divisor[int'(win)*N +: N];
        id <= win;
        ptr <= IW'((int'(win) + 1) % R);
      end
      if (state == BUSY && div_fin) begin
        q_r <= div_q;
        r_r <= div_r;
        u_r <= div_u;
      end
    end
  end
  assign o_grant = grant_en ? R'(1) << win : '0;
  assign o_busy = state != IDLE;
  assign o_valid = state == DONE;
  assign o_id = id;
  assign o_quotient = q_r;
  assign o_remainder = r_r;
  assign o_undefined = u_r;
endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed stimulus with a result scoreboard popped by a separate monitor.
module tb_divider_arbiter;
  localparam int N = 8;
  localparam int R = 4;
  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic [R-1:0] i_req = '0;
  logic [R*N-1:0] i_dividend = '0;
  logic [R*N-1:0] i_divisor = '0;
  logic i_ready = 1'b0;
  logic [R-1:0] o_grant;
  logic o_busy, o_valid, o_undefined;
  logic [1:0] o_id;
  logic [N-1:0] o_quotient, o_remainder;
  typedef struct {int id; int q; int r; int u;} exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  divider_arbiter #(.N(N), .R(R)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_req(i_req),
    .i_dividend(i_dividend),
    .i_divisor(i_divisor),
    .o_grant(o_grant),
    .o_busy(o_busy),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_id(o_id),
    .o_quotient(o_quotient),
    .o_remainder(o_remainder),
    .o_undefined(o_undefined)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_ops(int a, int b);
    for (int k = 0; k < R; k++) begin
      i_dividend[k*N +: N] = N'(a);
      i_divisor[k*N +: N] = N'(b);
    end
  endtask

  task automatic wait_valid(int start_k);
    int k;
    k = start_k;
    while (!o_valid && k < 30) begin
      step();
      k++;
    end
    check("latency", k, N + 2);
  endtask

  task automatic serve(int idx, int a, int b, int q, int r, int u, bit drop);
    int k;
    set_ops(a, b);
    #1;
    k = 0;
    while (o_grant == '0 && k < 20) begin
      step();
      k++;
    end
    check("grant", o_grant, 1 << idx);
    if (o_grant == '0) return;
    sb.push_back('{idx, q, r, u});
    step();
    if (drop) i_req[idx] = 1'b0;
    wait_valid(1);
  endtask

  always @(negedge i_clock) begin
    exp_t e;
    if (!i_reset && o_valid && i_ready) begin
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("id", o_id, e.id);
        check("quotient", o_quotient, e.q);
        check("remainder", o_remainder, e.r);
        check("undefined", o_undefined, e.u);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_ready = 1'b1;
    step();
    step();
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_grant", o_grant, 0);
    check("rst_id", o_id, 0);
    check("rst_q", o_quotient, 0);
    check("rst_r", o_remainder, 0);
    check("rst_u", o_undefined, 0);
    i_reset = 1'b0;
    // single request, 100/7
    i_req = 4'b0100;
    serve(2, 100, 7, 14, 2, 0, 1);
    // divide by zero; pointer now 3 so req[1] is reached after wrapping
    step();
    i_req = 4'b0010;
    serve(1, 13, 0, 255, 13, 1, 1);
    // back-pressure with all requesters pending
    step();
    i_ready = 1'b0;
    i_req = 4'b0001;
    serve(0, 255, 1, 255, 0, 0, 1);
    i_req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("hold_grant", o_grant, 0);
      check("hold_valid", o_valid, 1);
      check("hold_id", o_id, 0);
      check("hold_q", o_quotient, 255);
      check("hold_r", o_remainder, 0);
      step();
    end
    i_ready = 1'b1;
    i_req = '0;
    #1;
    check("accept_grant", o_grant, 0);
    step();
    // pointer back to 0, all requesters held
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_req = 4'b1111;
    serve(0, 200, 13, 15, 5, 0, 0);
    serve(1, 200, 13, 15, 5, 0, 0);
    serve(2, 200, 13, 15, 5, 0, 0);
    serve(3, 200, 13, 15, 5, 0, 0);
    serve(0, 200, 13, 15, 5, 0, 0);
    i_req = '0;
    step();
    // reset in the middle of a division
    i_req = 4'b0010;
    set_ops(50, 6);
    #1;
    check("mid_grant", o_grant, 4'b0010);
    step();
    i_req = '0;
    step();
    step();
    step();
    check("mid_busy_before", o_busy, 1);
    i_reset = 1'b1;
    step();
    check("mid_busy", o_busy, 0);
    check("mid_valid", o_valid, 0);
    check("mid_id", o_id, 0);
    check("mid_q", o_quotient, 0);
    check("mid_r", o_remainder, 0);
    check("mid_u", o_undefined, 0);
    i_reset = 1'b0;
    i_req = 4'b1000;
    serve(3, 50, 6, 8, 2, 0, 1);
    // req[0] raised and dropped while req[1] is being served
    step();
    i_req = 4'b0010;
    set_ops(77, 9);
    #1;
    check("drop_grant", o_grant, 4'b0010);
    sb.push_back('{1, 8, 5, 0});
    step();
    i_req = 4'b0001;
    step();
    step();
    i_req = '0;
    wait_valid(3);
    for (int c = 0; c < 5; c++) begin
      step();
      check("forgotten_grant", o_grant, 0);
    end
    i_req = 4'b1000;
    serve(3, 9, 10, 0, 9, 0, 1);
    step();
    step();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
